// File: rtl/conv3d_loop_sequencer_pkg.sv
// Shared types and elaboration helpers for the 3D convolution loop sequencer.
// Geometry functions are constant functions usable in localparams.
package conv3d_seq_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic int out_edge(int dim, int k, int stride);
        return (dim - k) / stride + 1;
    endfunction

    function automatic longint tap_count(int dim, int k, int cin, int cout, int stride);
        longint od;
        od = longint'(out_edge(dim, k, stride));
        return longint'(cout) * od * od * od * longint'(cin) * k * k * k;
    endfunction

    // True when every address space fits in addr_w bits and the kernel fits the input.
    function automatic bit addr_fits(int dim, int k, int cin, int cout, int stride, int addr_w);
        longint span;
        longint od;
        span = longint'(1) << addr_w;
        if (dim < k || stride < 1) begin
            return 1'b0;
        end
        od = longint'(out_edge(dim, k, stride));
        return (longint'(cout) * od * od * od <= span) &&
               (longint'(cin) * dim * dim * dim <= span) &&
               (longint'(cout) * cin * k * k * k <= span);
    endfunction

endpackage

// File: rtl/conv3d_loop_sequencer_if.sv
// Layer-control and MAC tap bus between the sequencer (master) and its environment (slave).
interface conv3d_loop_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              mac_valid;
    logic              mac_ready;
    logic              mac_first;
    logic              mac_last;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] wt_addr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        input  start, abort, mac_ready,
        output busy, done, mac_valid, mac_first, mac_last, in_addr, wt_addr, out_addr
    );

    modport slave (
        output start, abort, mac_ready,
        input  busy, done, mac_valid, mac_first, mac_last, in_addr, wt_addr, out_addr
    );
endinterface

// File: rtl/conv3d_loop_sequencer_wrap_cnt.sv
// Wrapping loop counter: counts 0..LIMIT-1 on enable, carry pulses when it wraps.
module conv3d_wrap_cnt #(
    parameter int W     = 16,
    parameter int LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_max,
    output logic         carry
);
    localparam logic [W-1:0] MAX_VAL = W'(LIMIT - 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    // Clear has priority so a restart or cancel overrides a coincident transfer.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = at_max ? '0 : cnt_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt    = cnt_reg;
    assign at_max = (cnt_reg == MAX_VAL);
    assign carry  = en && at_max;
endmodule

// File: rtl/conv3d_loop_sequencer.sv
// Walks the conv3d loop nest (oc, od, oh, ow, ic, kd, kh, kw) and presents one MAC tap
// per valid/ready transfer with input, weight and output buffer addresses.
module conv3d_loop_sequencer
    import conv3d_seq_pkg::*;
#(
    parameter int DIM    = 8,
    parameter int K      = 3,
    parameter int CIN    = 4,
    parameter int COUT   = 8,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    conv3d_loop_sequencer_if.master bus
);
    localparam int OD   = out_edge(DIM, K, STRIDE);
    localparam int NLVL = 8;

    localparam logic [ADDR_W-1:0] DIM_A = ADDR_W'(DIM);
    localparam logic [ADDR_W-1:0] K_A   = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] CIN_A = ADDR_W'(CIN);
    localparam logic [ADDR_W-1:0] OD_A  = ADDR_W'(OD);
    localparam logic [ADDR_W-1:0] S_A   = ADDR_W'(STRIDE);

    if (!addr_fits(DIM, K, CIN, COUT, STRIDE, ADDR_W)) begin : g_cfg_check
        $error("conv3d_loop_sequencer: address space exceeds ADDR_W or DIM < K");
    end

    // Level 0 is innermost (kw); level 7 is outermost (oc).
    function automatic int level_limit(int lvl);
        case (lvl)
            0, 1, 2: return K;
            3:       return CIN;
            4, 5, 6: return OD;
            default: return COUT;
        endcase
    endfunction

    state_t state_reg;
    state_t state_next;
    logic   done_reg;
    logic   done_next;
    logic   clr;
    logic   run;
    logic   xfer;
    logic   final_xfer;

    assign run  = (state_reg == RUN);
    assign xfer = run && bus.mac_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NLVL; gi++) begin : g_lvl
            logic              en_lvl;
            logic              carry_lvl;
            logic              max_lvl;
            logic [ADDR_W-1:0] cnt_lvl;

            if (gi == 0) begin : g_head
                assign en_lvl = xfer;
            end else begin : g_link
                assign en_lvl = g_lvl[gi-1].carry_lvl;
            end

            conv3d_wrap_cnt #(
                .W     (ADDR_W),
                .LIMIT (level_limit(gi))
            ) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .clr    (clr),
                .en     (en_lvl),
                .cnt    (cnt_lvl),
                .at_max (max_lvl),
                .carry  (carry_lvl)
            );
        end
    endgenerate

    logic [ADDR_W-1:0] cnt_kw, cnt_kh, cnt_kd, cnt_ic, cnt_ow, cnt_oh, cnt_od, cnt_oc;

    assign cnt_kw     = g_lvl[0].cnt_lvl;
    assign cnt_kh     = g_lvl[1].cnt_lvl;
    assign cnt_kd     = g_lvl[2].cnt_lvl;
    assign cnt_ic     = g_lvl[3].cnt_lvl;
    assign cnt_ow     = g_lvl[4].cnt_lvl;
    assign cnt_oh     = g_lvl[5].cnt_lvl;
    assign cnt_od     = g_lvl[6].cnt_lvl;
    assign cnt_oc     = g_lvl[7].cnt_lvl;
    assign final_xfer = g_lvl[NLVL-1].carry_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    // Abort clears the counters too, so IDLE always presents zero addresses.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        clr        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    clr        = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    clr        = 1'b1;
                end else if (final_xfer) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy      = run;
    assign bus.mac_valid = run;
    assign bus.done      = done_reg;
    assign bus.mac_first = run && (cnt_ic == '0) && (cnt_kd == '0) && (cnt_kh == '0) && (cnt_kw == '0);
    assign bus.mac_last  = run && g_lvl[3].max_lvl && g_lvl[2].max_lvl && g_lvl[1].max_lvl && g_lvl[0].max_lvl;

    assign bus.in_addr  = ((cnt_ic * DIM_A + cnt_od * S_A + cnt_kd) * DIM_A
                          + cnt_oh * S_A + cnt_kh) * DIM_A + cnt_ow * S_A + cnt_kw;
    assign bus.wt_addr  = (((cnt_oc * CIN_A + cnt_ic) * K_A + cnt_kd) * K_A + cnt_kh) * K_A + cnt_kw;
    assign bus.out_addr = ((cnt_oc * OD_A + cnt_od) * OD_A + cnt_oh) * OD_A + cnt_ow;
endmodule

// File: tb/tb_conv3d_loop_sequencer.sv
// Self-checking bench: two sequencer configurations checked against a flat-index loop model.
module tb_conv3d_loop_sequencer;

    typedef struct packed {
        logic [15:0] in_a;
        logic [15:0] wt_a;
        logic [15:0] out_a;
        logic        first;
        logic        last;
    } tap_t;

    typedef struct {
        int dim;
        int k;
        int cin;
        int cout;
        int s;
    } cfg_t;

    typedef struct {
        int   dut;
        int   tap;
        tap_t exp;
    } vec_t;

    localparam int NVEC = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start_d [2];
    logic abort_d [2];
    logic ready_d [2];

    conv3d_loop_sequencer_if #(.ADDR_W(16)) ifa ();
    conv3d_loop_sequencer_if #(.ADDR_W(16)) ifb ();

    assign ifa.start     = start_d[0];
    assign ifa.abort     = abort_d[0];
    assign ifa.mac_ready = ready_d[0];
    assign ifb.start     = start_d[1];
    assign ifb.abort     = abort_d[1];
    assign ifb.mac_ready = ready_d[1];

    conv3d_loop_sequencer #(
        .DIM(4), .K(3), .CIN(1), .COUT(1), .STRIDE(1), .ADDR_W(16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    conv3d_loop_sequencer #(
        .DIM(5), .K(3), .CIN(2), .COUT(2), .STRIDE(2), .ADDR_W(16)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    tap_t cur [2];
    logic vld [2];
    logic rdy [2];
    logic bsy [2];
    logic dn  [2];

    assign cur[0] = {ifa.in_addr, ifa.wt_addr, ifa.out_addr, ifa.mac_first, ifa.mac_last};
    assign cur[1] = {ifb.in_addr, ifb.wt_addr, ifb.out_addr, ifb.mac_first, ifb.mac_last};
    assign vld[0] = ifa.mac_valid;
    assign vld[1] = ifb.mac_valid;
    assign rdy[0] = ifa.mac_ready;
    assign rdy[1] = ifb.mac_ready;
    assign bsy[0] = ifa.busy;
    assign bsy[1] = ifb.busy;
    assign dn[0]  = ifa.done;
    assign dn[1]  = ifb.done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    tap_t cap [2][$];
    tap_t ref_q [$];
    int   busy_cnt [2];
    int   done_cnt [2];
    int   done_cyc [2];
    int   last_xfer_cyc [2];
    bit   stall_prev [2];
    tap_t prev_tap [2];
    cfg_t cfg [2];
    vec_t vecs [NVEC];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_tap(input string name, input tap_t act, input tap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual in=%0d wt=%0d out=%0d first=%0b last=%0b required in=%0d wt=%0d out=%0d first=%0b last=%0b",
                     name, act.in_a, act.wt_a, act.out_a, act.first, act.last,
                     exp.in_a, exp.wt_a, exp.out_a, exp.first, exp.last);
        end
    endtask

    // Reference: decompose the flat tap index into loop indices, then apply the address formulas.
    function automatic tap_t model_tap(cfg_t c, int n);
        int   od_e, r, kw, kh, kd, ic, ow, oh, od, oc;
        tap_t t;
        od_e = (c.dim - c.k) / c.s + 1;
        r  = n;
        kw = r % c.k;    r = r / c.k;
        kh = r % c.k;    r = r / c.k;
        kd = r % c.k;    r = r / c.k;
        ic = r % c.cin;  r = r / c.cin;
        ow = r % od_e;   r = r / od_e;
        oh = r % od_e;   r = r / od_e;
        od = r % od_e;   r = r / od_e;
        oc = r;
        t.in_a  = 16'(((ic * c.dim + od * c.s + kd) * c.dim + oh * c.s + kh) * c.dim + ow * c.s + kw);
        t.wt_a  = 16'((((oc * c.cin + ic) * c.k + kd) * c.k + kh) * c.k + kw);
        t.out_a = 16'(((oc * od_e + od) * od_e + oh) * od_e + ow);
        t.first = (ic == 0) && (kd == 0) && (kh == 0) && (kw == 0);
        t.last  = (ic == c.cin - 1) && (kd == c.k - 1) && (kh == c.k - 1) && (kw == c.k - 1);
        return t;
    endfunction

    function automatic int total_taps(cfg_t c);
        int od_e;
        od_e = (c.dim - c.k) / c.s + 1;
        return c.cout * od_e * od_e * od_e * c.cin * c.k * c.k * c.k;
    endfunction

    function automatic vec_t mk(int dut, int tap, int in_a, int wt_a, int out_a, bit first, bit last);
        vec_t v;
        v.dut = dut;
        v.tap = tap;
        v.exp = {16'(in_a), 16'(wt_a), 16'(out_a), first, last};
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: capture transfers, count busy/done, and require held outputs during stalls.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (stall_prev[d]) begin
                chk_tap($sformatf("stall_hold_dut%0d_cyc%0d", d, cyc), cur[d], prev_tap[d]);
                chk($sformatf("stall_valid_dut%0d_cyc%0d", d, cyc), vld[d], 1);
            end
            stall_prev[d] = vld[d] && !rdy[d];
            prev_tap[d]   = cur[d];
            if (vld[d] && rdy[d]) begin
                cap[d].push_back(cur[d]);
                last_xfer_cyc[d] = cyc;
            end
            if (bsy[d]) busy_cnt[d]++;
            if (dn[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_zero(input int d, input string name);
        chk({name, "_busy"}, bsy[d], 0);
        chk({name, "_done"}, dn[d], 0);
        chk({name, "_valid"}, vld[d], 0);
        chk_tap({name, "_outs"}, cur[d], '0);
    endtask

    task automatic wait_done(input int d, input bit rnd, input int mid_start, input int budget, input string name);
        int c = 0;
        while (done_cnt[d] == 0 && c < budget) begin
            ready_d[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_d[d] = (c == mid_start);
            @(posedge clk);
            #1;
            c++;
        end
        start_d[d] = 1'b0;
        ready_d[d] = 1'b1;
        chk({name, "_finished"}, done_cnt[d] != 0, 1);
        chk({name, "_done_pulses"}, done_cnt[d], 1);
        chk({name, "_done_lag"}, done_cyc[d] - last_xfer_cyc[d], 1);
    endtask

    task automatic run_pass(input int d, input bit rnd, input int mid_start, input int budget, input string name);
        cap[d].delete();
        done_cnt[d] = 0;
        start_d[d]  = 1'b1;
        @(posedge clk);
        #1;
        start_d[d] = 1'b0;
        wait_done(d, rnd, mid_start, budget, name);
    endtask

    initial begin
        tap_t got [2][$];
        for (int d = 0; d < 2; d++) begin
            start_d[d] = 1'b0;
            abort_d[d] = 1'b0;
            ready_d[d] = 1'b0;
            busy_cnt[d] = 0;
            done_cnt[d] = 0;
            done_cyc[d] = 0;
            last_xfer_cyc[d] = 0;
            stall_prev[d] = 1'b0;
        end
        cfg[0] = '{dim: 4, k: 3, cin: 1, cout: 1, s: 1};
        cfg[1] = '{dim: 5, k: 3, cin: 2, cout: 2, s: 2};

        vecs[0]  = mk(0, 0,     0,   0,  0, 1'b1, 1'b0);
        vecs[1]  = mk(0, 1,     1,   1,  0, 1'b0, 1'b0);
        vecs[2]  = mk(0, 3,     4,   3,  0, 1'b0, 1'b0);
        vecs[3]  = mk(0, 9,    16,   9,  0, 1'b0, 1'b0);
        vecs[4]  = mk(0, 26,   42,  26,  0, 1'b0, 1'b1);
        vecs[5]  = mk(0, 27,    1,   0,  1, 1'b1, 1'b0);
        vecs[6]  = mk(0, 215,  63,  26,  7, 1'b0, 1'b1);
        vecs[7]  = mk(1, 53,  187,  53,  0, 1'b0, 1'b1);
        vecs[8]  = mk(1, 54,    2,   0,  1, 1'b1, 1'b0);
        vecs[9]  = mk(1, 863, 249, 107, 15, 1'b0, 1'b1);
        vecs[10] = mk(1, 0,     0,   0,  0, 1'b1, 1'b0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");

        // Ready-high pass on A, with a back-to-back start in its done cycle.
        @(posedge clk);
        #1;
        cap[0].delete();
        busy_cnt[0] = 0;
        done_cnt[0] = 0;
        ready_d[0]  = 1'b1;
        start_d[0]  = 1'b1;
        @(posedge clk);
        #1;
        start_d[0] = 1'b0;
        chk_tap("a1_tap0_presented", cur[0], model_tap(cfg[0], 0));
        repeat (216) @(posedge clk);
        #1;
        chk("a1_done_cycle", dn[0], 1);
        chk("a1_valid_in_done", vld[0], 0);
        chk("a1_busy_in_done", bsy[0], 0);
        chk("a1_taps", cap[0].size(), total_taps(cfg[0]));
        chk("a1_busy_cycles", busy_cnt[0], 216);
        ref_q = cap[0];
        cap[0].delete();
        start_d[0] = 1'b1;
        @(negedge clk);
        #1;
        chk("a1_done_pulses", done_cnt[0], 1);
        chk("a1_done_lag", done_cyc[0] - last_xfer_cyc[0], 1);
        done_cnt[0] = 0;
        @(posedge clk);
        #1;
        start_d[0] = 1'b0;
        chk("a2_started_after_done", vld[0], 1);
        wait_done(0, 1'b0, -1, 400, "a2");
        chk("a2_taps", cap[0].size(), 216);
        for (int i = 0; i < ref_q.size(); i++) begin
            chk_tap($sformatf("a1_model_tap%0d", i), ref_q[i], model_tap(cfg[0], i));
            if (i < cap[0].size()) chk_tap($sformatf("a2_vs_a1_tap%0d", i), cap[0][i], ref_q[i]);
        end
        $display("pass a1/a2 ready-high back-to-back: %0d and %0d taps", ref_q.size(), cap[0].size());

        // Random ready on A, with a start pulse mid-run that must be ignored.
        run_pass(0, 1'b1, 40, 2000, "a3");
        chk("a3_taps", cap[0].size(), 216);
        for (int i = 0; i < cap[0].size() && i < ref_q.size(); i++) begin
            chk_tap($sformatf("a3_vs_a1_tap%0d", i), cap[0][i], ref_q[i]);
        end
        $display("pass a3 random-ready: %0d taps", cap[0].size());

        // Abort while tap 100 is presented.
        cap[0].delete();
        done_cnt[0] = 0;
        ready_d[0]  = 1'b1;
        start_d[0]  = 1'b1;
        @(posedge clk);
        #1;
        start_d[0] = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk_tap("abort_tap100", cur[0], model_tap(cfg[0], 100));
        abort_d[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_d[0] = 1'b0;
        chk("abort_valid", vld[0], 0);
        chk("abort_busy", bsy[0], 0);
        chk("abort_done", dn[0], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt[0], 0);
        start_d[0] = 1'b1;
        @(posedge clk);
        #1;
        start_d[0] = 1'b0;
        chk("restart_valid", vld[0], 1);
        chk_tap("restart_tap0", cur[0], model_tap(cfg[0], 0));
        $display("pass a4 abort at tap 100: %0d taps before abort", cap[0].size());

        // Synchronous reset in the middle of a pass.
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_zero(0, "rst_mid_a");
        check_zero(1, "rst_mid_b");

        // Stride-2 configuration on B with random ready.
        @(posedge clk);
        #1;
        run_pass(1, 1'b1, 100, 6000, "b1");
        chk("b1_taps", cap[1].size(), total_taps(cfg[1]));
        for (int i = 0; i < cap[1].size(); i++) begin
            chk_tap($sformatf("b1_model_tap%0d", i), cap[1][i], model_tap(cfg[1], i));
        end
        $display("pass b1 stride-2 random-ready: %0d taps", cap[1].size());

        got[0] = ref_q;
        got[1] = cap[1];
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].tap < got[vecs[i].dut].size()) begin
                chk_tap($sformatf("vec%0d_dut%0d_tap%0d", i, vecs[i].dut, vecs[i].tap),
                        got[vecs[i].dut][vecs[i].tap], vecs[i].exp);
            end else begin
                chk($sformatf("vec%0d_missing_tap", i), got[vecs[i].dut].size(), vecs[i].tap + 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
